// File: rtl/seg_pkg.sv
// Shared definitions for the score display path: digit count, display limit,
// converter FSM encoding and the BCD nibble type.
package seg_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int MAX_DISP   = 9999;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/score_bcd_conv_bcd_adj3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the
// shift, so that doubling it carries correctly into the next decade.
module bcd_adj3
    import seg_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Pure combinational correction; inputs never exceed 9, so +3 cannot wrap.
    always_comb begin
        digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
    end

endmodule

// File: rtl/score_bcd_conv.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock)
// feeding the 4-digit seven-segment scan controller. The displayed digits
// are held in their own registers and only updated when a conversion
// completes, so the display never shows partial results.
// Optional feature: define SCORE_SAT_EN to clamp the display at 9999 when
// the value does not fit in four digits (ovf is reported either way).
module score_bcd_conv
    import seg_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       D,
    output logic [3:0]       C,
    output logic [3:0]       B,
    output logic [3:0]       A
);

    localparam int SCR_DIGITS = BCD_DIGITS + 1;
    localparam int SCR_W      = 4 * SCR_DIGITS;
    localparam int DISP_W     = 4 * BCD_DIGITS;
    localparam int CNT_W      = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    shreg_q, shreg_d;
    logic [SCR_W-1:0]    scr_q, scr_d;
    logic [SCR_W-1:0]    scr_adj;
    logic [DISP_W-1:0]   disp_q, disp_d;
    logic                ovf_q, ovf_d;

    // One +3 corrector per scratch digit, including the overflow digit.
    for (genvar g = 0; g < SCR_DIGITS; g++) begin : g_adj
        bcd_adj3 u_adj (
            .digit_i (scr_q[4*g +: 4]),
            .digit_o (scr_adj[4*g +: 4])
        );
    end

    // Next-state logic: capture, shift one bit per clock, then publish digits.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        scr_d   = scr_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = bin;
                    scr_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (cnt_q < LAST_CNT) begin
                    {scr_d, shreg_d} = {scr_adj, shreg_q} << 1;
                    cnt_d            = cnt_q + 1'b1;
                end else begin
                    ovf_d  = (scr_q[SCR_W-1 -: 4] != 4'd0);
                    disp_d = scr_q[DISP_W-1:0];
`ifdef SCORE_SAT_EN
                    if (ovf_d) begin
                        disp_d = {BCD_DIGITS{4'd9}};
                    end
`endif
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and display registers; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all registers here are small flops, so each gets an explicit async reset value.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            scr_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            scr_q   <= scr_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign ovf  = ovf_q;
    assign D    = disp_q[15:12];
    assign C    = disp_q[11:8];
    assign B    = disp_q[7:4];
    assign A    = disp_q[3:0];

endmodule

// File: tb/tb_score_bcd_conv.sv
// Self-checking bench for score_bcd_conv: directed cases plus random values,
// with expected digits computed arithmetically from the binary value.
module tb_score_bcd_conv;

    localparam int BIN_W   = 14;
    localparam int LATENCY = BIN_W + 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin   = '0;
    logic             busy, done, ovf;
    logic [3:0]       D, C, B, A;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] prev_digits = 16'h0000;
    logic        prev_ovf    = 1'b0;

    score_bcd_conv #(.BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .D     (D),
        .C     (C),
        .B     (B),
        .A     (A)
    );

    always #5 clk = ~clk;

    // Reference: value shown on the display for a given binary input.
    function automatic logic [15:0] model_digits(int v);
        int s;
        s = v;
        if (v > 9999) begin
`ifdef SCORE_SAT_EN
            s = 9999;
`else
            s = v % 10000;
`endif
        end
        return {4'((s / 1000) % 10), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] shown();
        return 32'({D, C, B, A});
    endfunction

    // Run one conversion starting from IDLE, optionally poking start while busy.
    task automatic convert(int value, bit glitch);
        int n;
        bit got;
        start = 1'b1;
        bin   = BIN_W'(value);
        @(posedge clk); #1;
        start = 1'b0;
        bin   = BIN_W'($urandom);
        n     = 0;
        got   = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        while (!got && n < 3 * LATENCY) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (n < BIN_W) check("busy_during", 32'(busy), 32'd1);
                check("digits_hold", shown(), 32'(prev_digits));
                check("ovf_hold", 32'(ovf), 32'(prev_ovf));
                if (glitch && n == 3) begin
                    start = 1'b1;
                    bin   = BIN_W'(777);
                end
                if (glitch && n == 5) start = 1'b0;
                @(posedge clk); #1;
                n++;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(n), 32'(LATENCY));
        check("busy_at_done", 32'(busy), 32'd0);
        prev_digits = model_digits(value);
        prev_ovf    = (value > 9999);
        check("digits", shown(), 32'(prev_digits));
        check("ovf", 32'(ovf), 32'(prev_ovf));
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        if (glitch) begin
            repeat (20) begin
                @(posedge clk); #1;
                check("no_queued_start", 32'(busy | done), 32'd0);
            end
        end
    endtask

    initial begin
        int v;
        repeat (2) @(posedge clk);
        #1;
        check("reset_digits", shown(), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        convert(1234, 1'b0);
        convert(9999, 1'b0);
        convert(0, 1'b0);
        convert(10, 1'b0);
        convert(12345, 1'b0);
        convert(42, 1'b1);

        // Reset in the middle of a conversion, after earlier digits were shown.
        start = 1'b1;
        bin   = BIN_W'(3000);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_digits", shown(), 32'd0);
        check("midrun_reset_ovf", 32'(ovf), 32'd0);
        check("midrun_reset_busy", 32'(busy), 32'd0);
        check("midrun_reset_done", 32'(done), 32'd0);
        prev_digits = 16'h0000;
        prev_ovf    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            check("no_done_after_reset", 32'(busy | done), 32'd0);
        end

        convert(56, 1'b0);
        convert(16383, 1'b0);
        convert(10000, 1'b0);

        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 16383));
            convert(v, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
